// File: rtl/seg_scan_bcd.sv
// Three-digit multiplexed 7-segment driver for a packed BCD value.
// Scans ones/tens/hundreds with optional leading-zero blanking.
module seg_scan_bcd #(
    parameter int SCAN_DIV = 50000,
    parameter bit LZB      = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] bcd_in,
    input  logic       din_vld,
    output logic [7:0] seg,
    output logic [2:0] sel,
    output logic       err,
    output logic       frame_tick
);

    typedef enum logic [1:0] {
        ONES = 2'd0,
        TENS = 2'd1,
        HUND = 2'd2
    } idx_t;

    logic [9:0]  bcd_reg;
    logic [15:0] cnt;
    idx_t        idx;
    logic        adv;
    logic [1:0]  hund;
    logic [3:0]  tens;
    logic [3:0]  ones;
    logic        bad;
    logic [7:0]  seg_d;
    logic [2:0]  sel_d;

    function automatic logic [7:0] dec(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    assign adv  = (cnt == 16'(SCAN_DIV - 1));
    assign hund = bcd_reg[9:8];
    assign tens = bcd_reg[7:4];
    assign ones = bcd_reg[3:0];
    assign bad  = (ones > 4'd9) || (tens > 4'd9) || (hund == 2'd3);

    // Blanking of a leading zero only applies when the digits above it are zero too.
    always_comb begin
        seg_d = 8'hFF;
        sel_d = 3'b111;
        case (idx)
            ONES: begin
                seg_d = dec(ones);
                sel_d = 3'b110;
            end
            TENS: begin
                seg_d = (LZB && hund == 2'd0 && tens == 4'd0) ? 8'hFF : dec(tens);
                sel_d = 3'b101;
            end
            HUND: begin
                seg_d = ((LZB && hund == 2'd0) || hund == 2'd3)
                        ? 8'hFF : dec({2'b00, hund});
                sel_d = 3'b011;
            end
            default: begin
                seg_d = 8'hFF;
                sel_d = 3'b111;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_reg    <= '0;
            cnt        <= '0;
            idx        <= ONES;
            seg        <= 8'hFF;
            sel        <= 3'b111;
            err        <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            if (din_vld)
                bcd_reg <= bcd_in;
            cnt        <= adv ? '0 : cnt + 16'd1;
            frame_tick <= adv && (idx == HUND);
            if (adv) begin
                case (idx)
                    ONES:    idx <= TENS;
                    TENS:    idx <= HUND;
                    default: idx <= ONES;
                endcase
            end
            seg <= seg_d;
            sel <= sel_d;
            err <= bad;
        end
    end

endmodule
